picc_tx_scheduler: RTL and testbench

- Sequences the card-to-reader load-modulation transmitter.
- After a reader (PCD) frame ends, waits the ISO 14443-3 frame delay time (FDT) and grants one of N_REQ responders (REQA/ATQA, anticollision/UID, SAK, …) by round robin.
- Presents the granted payload to the transmitter, holds the trigger until the transmitter reports busy, waits for completion, then signals done to the requester.
- Sits between the protocol responders and the transmitter; clk_in is the 13.56 MHz carrier clock.

---
 rtl/picc_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/picc_tx_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_picc_tx_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picc_sched_pkg.sv
// Shared state encoding and frame constants for the PICC transmit scheduler.
package picc_sched_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_FDT, TRIGGER, SENDING, DONE} state_t;

  localparam int FDT_LAST0_DEF = 1172;
  localparam int FDT_LAST1_DEF = 1236;
  localparam int MAX_BYTES     = 5;
  localparam int PAYLOAD_W     = 40;
  localparam int NBYTES_W      = 3;
  localparam int CNT_W         = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W:0] k;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    k     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (k >= (IDX_W + 1)'(N_REQ)) k = k - (IDX_W + 1)'(N_REQ);
      if (req[k[IDX_W-1:0]]) begin
        valid = 1'b1;
        index = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/picc_tx_scheduler.sv
// Waits the ISO 14443-3 frame delay after a PCD frame, grants one responder by
// round robin and hands its payload to the load-modulation transmitter.
module picc_tx_scheduler
  import picc_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FDT_LAST0    = FDT_LAST0_DEF,
  parameter int FDT_LAST1    = FDT_LAST1_DEF,
  parameter int TRIG_TIMEOUT = 2048
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rx_end_in,
  input  logic                          rx_last_bit_in,
  input  logic [N_REQ-1:0]              req_in,
  input  logic [N_REQ*PAYLOAD_W-1:0]    req_data_in,
  input  logic [N_REQ*NBYTES_W-1:0]     req_nbytes_in,
  output logic [N_REQ-1:0]              done_out,
  output logic                          err_out,
  output logic                          miss_out,
  output logic [PAYLOAD_W-1:0]          tx_data_out,
  output logic [NBYTES_W-1:0]           tx_num_bytes_out,
  output logic                          tx_trigger_out,
  input  logic                          tx_busy_in,
  output logic                          busy_out,
  output logic [$clog2(N_REQ)-1:0]      grant_out
);

  localparam int IDX_W = $clog2(N_REQ);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     fdt_cnt_q, fdt_cnt_d;
  logic [CNT_W-1:0]     fdt_tgt_q, fdt_tgt_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 armed_q, armed_d;
  logic [IDX_W-1:0]     grant_d;
  logic [PAYLOAD_W-1:0] data_d;
  logic [NBYTES_W-1:0]  nbytes_d;
  logic                 trig_d, err_d, miss_d;
  logic [N_REQ-1:0]     done_d;
  logic                 busy_p0, busy_p1;
  logic                 arb_valid;
  logic [IDX_W-1:0]     arb_idx;
  logic [CNT_W-1:0]     tgt_sel;
  logic                 nbytes_ok;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_in),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .index (arb_idx)
  );

  assign tgt_sel   = rx_last_bit_in ? CNT_W'(FDT_LAST1) : CNT_W'(FDT_LAST0);
  assign nbytes_ok = (tx_num_bytes_out != '0) &&
                     (tx_num_bytes_out <= NBYTES_W'(MAX_BYTES));
  assign busy_out  = (state_q != IDLE);

  // Stage p0/p1: tx_busy_in crosses from the slower transmitter clock.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_p0 <= 1'b0;
      busy_p1 <= 1'b0;
    end else begin
      busy_p0 <= tx_busy_in;
      busy_p1 <= busy_p0;
    end
  end

  always_comb begin
    state_d   = state_q;
    fdt_cnt_d = fdt_cnt_q;
    fdt_tgt_d = fdt_tgt_q;
    tmo_d     = tmo_q;
    ptr_d     = ptr_q;
    armed_d   = armed_q;
    grant_d   = grant_out;
    data_d    = tx_data_out;
    nbytes_d  = tx_num_bytes_out;
    trig_d    = tx_trigger_out;
    done_d    = '0;
    err_d     = 1'b0;
    miss_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_end_in) begin
          state_d   = WAIT_FDT;
          fdt_cnt_d = '0;
          fdt_tgt_d = tgt_sel;
          armed_d   = 1'b0;
        end
      end
      WAIT_FDT: begin
        if (rx_end_in) begin
          fdt_cnt_d = '0;
          fdt_tgt_d = tgt_sel;
          armed_d   = 1'b0;
        end else if (armed_q) begin
          // Grant was latched last cycle; now vet the byte count.
          armed_d = 1'b0;
          if (nbytes_ok) begin
            trig_d  = 1'b1;
            tmo_d   = CNT_W'(1);
            state_d = TRIGGER;
          end else begin
            done_d[grant_out] = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (fdt_cnt_q == fdt_tgt_q - CNT_W'(1)) begin
          if (!arb_valid) begin
            miss_d  = 1'b1;
            state_d = IDLE;
          end else begin
            grant_d  = arb_idx;
            data_d   = req_data_in[arb_idx*PAYLOAD_W +: PAYLOAD_W];
            nbytes_d = req_nbytes_in[arb_idx*NBYTES_W +: NBYTES_W];
            ptr_d    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            armed_d  = 1'b1;
          end
        end else begin
          fdt_cnt_d = sat_inc(fdt_cnt_q);
        end
      end
      TRIGGER: begin
        if (busy_p1) begin
          trig_d  = 1'b0;
          state_d = SENDING;
        end else if (tmo_q >= CNT_W'(TRIG_TIMEOUT)) begin
          trig_d  = 1'b0;
          done_d[grant_out] = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = sat_inc(tmo_q);
        end
      end
      SENDING: begin
        if (!busy_p1) begin
          done_d[grant_out] = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rx_end_in) begin
          state_d   = WAIT_FDT;
          fdt_cnt_d = '0;
          fdt_tgt_d = tgt_sel;
          armed_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      fdt_cnt_q        <= '0;
      fdt_tgt_q        <= '0;
      tmo_q            <= '0;
      ptr_q            <= '0;
      armed_q          <= 1'b0;
      grant_out        <= '0;
      tx_data_out      <= '0;
      tx_num_bytes_out <= '0;
      tx_trigger_out   <= 1'b0;
      done_out         <= '0;
      err_out          <= 1'b0;
      miss_out         <= 1'b0;
    end else begin
      state_q          <= state_d;
      fdt_cnt_q        <= fdt_cnt_d;
      fdt_tgt_q        <= fdt_tgt_d;
      tmo_q            <= tmo_d;
      ptr_q            <= ptr_d;
      armed_q          <= armed_d;
      grant_out        <= grant_d;
      tx_data_out      <= data_d;
      tx_num_bytes_out <= nbytes_d;
      tx_trigger_out   <= trig_d;
      done_out         <= done_d;
      err_out          <= err_d;
      miss_out         <= miss_d;
    end
  end

endmodule

// File: tb/tb_picc_tx_scheduler.sv
// Scoreboard bench for picc_tx_scheduler with a simple transmitter stub.
module tb_picc_tx_scheduler;

  localparam int N    = 4;
  localparam int FDT0 = 1172;
  localparam int FDT1 = 1236;
  localparam int TMO  = 2048;

  localparam int EV_NONE = 0;
  localparam int EV_TRIG = 1;
  localparam int EV_DONE = 2;
  localparam int EV_MISS = 3;

  typedef struct {
    int             kind;
    longint         cyc;
    int             grant;
    logic [39:0]    data;
    int             nbytes;
    logic [N-1:0]   done;
    bit             err;
  } ev_t;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic           rx_end_in = 1'b0;
  logic           rx_last_bit_in = 1'b0;
  logic [N-1:0]   req_in = '0;
  logic [N*40-1:0] req_data_in = '0;
  logic [N*3-1:0] req_nbytes_in = '0;
  logic [N-1:0]   done_out;
  logic           err_out, miss_out;
  logic [39:0]    tx_data_out;
  logic [2:0]     tx_num_bytes_out;
  logic           tx_trigger_out;
  logic           tx_busy_in = 1'b0;
  logic           busy_out;
  logic [1:0]     grant_out;

  picc_tx_scheduler #(.N_REQ(N)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rx_end_in        (rx_end_in),
    .rx_last_bit_in   (rx_last_bit_in),
    .req_in           (req_in),
    .req_data_in      (req_data_in),
    .req_nbytes_in    (req_nbytes_in),
    .done_out         (done_out),
    .err_out          (err_out),
    .miss_out         (miss_out),
    .tx_data_out      (tx_data_out),
    .tx_num_bytes_out (tx_num_bytes_out),
    .tx_trigger_out   (tx_trigger_out),
    .tx_busy_in       (tx_busy_in),
    .busy_out         (busy_out),
    .grant_out        (grant_out)
  );

  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_err = 0;
  ev_t         exp_q[$];
  logic [39:0] dat_m[N];
  int          nb_m[N];
  int          ptr_m = 0;
  bit          stub_en = 1'b1;
  int          stub_len = 500;
  bit          trig_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic apply_payloads();
    for (int i = 0; i < N; i++) begin
      req_data_in[i*40 +: 40] = dat_m[i];
      req_nbytes_in[i*3 +: 3] = 3'(nb_m[i]);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (p + i) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic push_ev(input int kind, input longint c, input int g, input bit err);
    ev_t e;
    e.kind   = kind;
    e.cyc    = c;
    e.grant  = g;
    e.data   = (g >= 0) ? dat_m[g] : '0;
    e.nbytes = (g >= 0) ? nb_m[g] : 0;
    e.done   = (g >= 0 && kind == EV_DONE) ? N'(1 << g) : '0;
    e.err    = err;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rx(input bit last, output longint r);
    @(posedge clk_in); #1;
    rx_end_in = 1'b1;
    rx_last_bit_in = last;
    @(posedge clk_in); #1;
    r = cyc;
    rx_end_in = 1'b0;
    rx_last_bit_in = 1'b0;
  endtask

  // Drives one PCD frame end and records what the scheduler must do with it.
  task automatic run_frame(input bit last, input bit with_done);
    longint r;
    int     fdt, g;
    pulse_rx(last, r);
    fdt = last ? FDT1 : FDT0;
    g = rr_pick(req_in, ptr_m);
    if (g < 0) begin
      push_ev(EV_MISS, r + fdt, -1, 1'b0);
    end else begin
      ptr_m = (g + 1) % N;
      if (nb_m[g] == 0 || nb_m[g] > 5) begin
        push_ev(EV_DONE, r + fdt + 1, g, 1'b1);
      end else begin
        push_ev(EV_TRIG, r + fdt + 1, g, 1'b0);
        if (!stub_en)
          push_ev(EV_DONE, r + fdt + 1 + TMO, g, 1'b1);
        else if (with_done)
          push_ev(EV_DONE, -1, g, 1'b0);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_in);
      n++;
    end
    check_eq("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (20) @(posedge clk_in);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("spurious_event", kind, EV_NONE);
      return;
    end
    e = exp_q.pop_front();
    check_eq("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    if (e.cyc >= 0) check_eq("event_cycle", cyc, e.cyc);
    case (kind)
      EV_TRIG: begin
        check_eq("trig_grant", grant_out, e.grant);
        check_eq("trig_data", tx_data_out, e.data);
        check_eq("trig_nbytes", tx_num_bytes_out, e.nbytes);
        check_eq("trig_busy_out", busy_out, 1);
      end
      EV_DONE: begin
        check_eq("done_vector", done_out, e.done);
        check_eq("done_err", err_out, e.err);
        check_eq("done_data_held", tx_data_out, e.data);
      end
      default: begin
        check_eq("miss_err", err_out, 0);
        check_eq("miss_trigger", tx_trigger_out, 0);
      end
    endcase
  endtask

  // Monitor: turns DUT output pulses/edges into events for the scoreboard.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (tx_trigger_out && !trig_prev) observe(EV_TRIG);
        if (done_out != '0) observe(EV_DONE);
        if (miss_out) observe(EV_MISS);
        if (err_out && done_out == '0) check_eq("err_without_done", err_out, 0);
      end
      trig_prev = tx_trigger_out;
    end
  end

  // Transmitter stub: reports busy a little after seeing the trigger.
  initial begin
    forever begin
      @(negedge clk_in);
      if (stub_en && tx_trigger_out && !tx_busy_in) begin
        repeat (2) @(negedge clk_in);
        tx_busy_in = 1'b1;
        repeat (stub_len) @(negedge clk_in);
        tx_busy_in = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_done"}, done_out, 0);
    check_eq({tag, "_err"}, err_out, 0);
    check_eq({tag, "_miss"}, miss_out, 0);
    check_eq({tag, "_trig"}, tx_trigger_out, 0);
    check_eq({tag, "_busy"}, busy_out, 0);
    check_eq({tag, "_grant"}, grant_out, 0);
    check_eq({tag, "_data"}, tx_data_out, 0);
    check_eq({tag, "_nbytes"}, tx_num_bytes_out, 0);
  endtask

  initial begin
    longint r0;
    int     n;
    dat_m[0] = 40'h00_0000_0044;  nb_m[0] = 2;
    dat_m[1] = 40'hA1_B2C3_D4E5;  nb_m[1] = 5;
    dat_m[2] = 40'h00_0011_2233;  nb_m[2] = 3;
    dat_m[3] = 40'hDE_ADBE_EF01;  nb_m[3] = 1;
    apply_payloads();

    repeat (5) @(posedge clk_in);
    #2;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (5) @(posedge clk_in);

    // Single request, last bit 0.
    req_in = 4'b0001;
    run_frame(1'b0, 1'b1);
    wait_drain(4000);

    // Round robin with two and then four requesters held.
    req_in = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      run_frame(1'b0, 1'b1);
      wait_drain(4000);
    end
    req_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_frame(i[0], 1'b1);
      wait_drain(4000);
    end

    // Nothing pending.
    req_in = 4'b0000;
    run_frame(1'b0, 1'b1);
    wait_drain(4000);
    run_frame(1'b1, 1'b1);
    wait_drain(4000);

    // Rejected byte counts, then a normal frame.
    nb_m[1] = 0;
    nb_m[3] = 6;
    apply_payloads();
    req_in = 4'b0010;
    run_frame(1'b0, 1'b1);
    wait_drain(4000);
    req_in = 4'b1000;
    run_frame(1'b1, 1'b1);
    wait_drain(4000);
    nb_m[1] = 5;
    nb_m[3] = 1;
    apply_payloads();
    req_in = 4'b0011;
    run_frame(1'b0, 1'b1);
    wait_drain(4000);

    // Transmitter never answers.
    stub_en = 1'b0;
    req_in = 4'b0001;
    run_frame(1'b0, 1'b1);
    wait_drain(6000);
    stub_en = 1'b1;

    // A second frame end restarts the delay.
    req_in = 4'b0100;
    pulse_rx(1'b0, r0);
    repeat (600) @(posedge clk_in);
    run_frame(1'b0, 1'b1);
    wait_drain(4000);

    // Reset while the transmitter is sending.
    req_in = 4'b0100;
    run_frame(1'b1, 1'b0);
    wait_drain(4000);
    n = 0;
    while (!tx_busy_in && n < 100) begin
      @(posedge clk_in);
      n++;
    end
    check_eq("stub_busy_seen", tx_busy_in, 1);
    repeat (10) @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    ptr_m = 0;
    n = 0;
    while (tx_busy_in && n < 1000) begin
      @(posedge clk_in);
      n++;
    end
    check_eq("stub_idle", tx_busy_in, 0);
    repeat (10) @(posedge clk_in);
    req_in = 4'b1001;
    run_frame(1'b0, 1'b1);
    wait_drain(4000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
